// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between NREQ byte producers.
// Define UART_TX_ARB_LOCK_EN to keep the grant on one requester until its packet ends.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*8-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_idle,
    output logic              o_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_err;
    logic [WW-1:0]   r_wait_cnt;

    logic [7:0]      w_data_arr [NREQ];
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_onehot;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic            w_found;
    logic            w_hold;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = i_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_TX_ARB_LOCK_EN
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    logic          r_locked;
    logic [LW-1:0] r_lock_cnt;

    // While locked, r_grant is the owner's one-hot, so it doubles as the eligibility mask.
    assign w_elig = r_locked ? (i_req & r_grant) : i_req;
    assign w_hold = r_locked;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^i_last ^ LOCK_TIMEOUT[0];
    assign w_elig        = i_req;
    assign w_hold        = 1'b0;
`endif

    // Scan downward so the nearest eligible requester after r_ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IW'(NREQ - 1);
            r_owner    <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
`endif
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (r_locked && ((i_req & r_grant) == '0)) begin
                        if (r_lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                            r_locked   <= 1'b0;
                            r_grant    <= '0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + LW'(1);
                        end
                    end else begin
                        r_lock_cnt <= '0;
                    end
`endif
                    // A busy sender here belongs to a foreign path; wait it out.
                    if (!i_tx_busy && w_found) begin
                        r_grant   <= w_onehot;
                        r_ack     <= w_onehot;
                        r_owner   <= w_win;
                        r_tx_data <= w_data_arr[w_win];
                        r_state   <= S_LOAD;
`ifdef UART_TX_ARB_LOCK_EN
                        r_locked  <= ~i_last[w_win];
`endif
                    end
                end
                S_LOAD: begin
                    r_tx_start <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_wait_cnt == WW'(BUSY_WAIT - 1)) begin
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_state <= S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        r_locked <= 1'b0;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                S_WAIT_LO: begin
                    // Pointer only moves on a completed frame, never on an abort.
                    if (!i_tx_busy) begin
                        r_ptr   <= r_owner;
                        r_state <= S_IDLE;
                        if (!w_hold) begin
                            r_grant <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_grant    = r_grant;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_err      = r_err;
    assign o_idle     = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a rotation model predicts byte order, a monitor checks ACK/TX_START.
// Lock scenarios run only when UART_TX_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int BUSY_WAIT = 4;
    localparam int LOCK_TO   = 50;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   tb_req;
    logic [NREQ*8-1:0] tb_data;
    logic [NREQ-1:0]   tb_last;
    logic [NREQ-1:0]   o_ack;
    logic [NREQ-1:0]   o_grant;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              tx_busy;
    logic              o_idle;
    logic              o_err;

    uart_tx_arbiter #(
        .NREQ(NREQ), .BUSY_WAIT(BUSY_WAIT), .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(tb_req), .i_data(tb_data), .i_last(tb_last),
        .o_ack(o_ack), .o_grant(o_grant), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_tx_busy(tx_busy), .o_idle(o_idle), .o_err(o_err)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rq_d [NREQ][16];
    logic       rq_l [NREQ][16];
    int         rq_head [NREQ];
    int         rq_cnt  [NREQ];

    int total, bad, cyc;
    int ack_cnt, start_cnt, err_cnt, idle_grant_seen;
    int last_ack_cyc, last_start_cyc, last_err_cyc;
    int m_ptr, m_owner;
    bit m_locked;
    bit force_busy, sender_dead, pend;
    int busy_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Sender model: BUSY rises one cycle after START is seen and stays high for a random frame length.
    initial begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (force_busy) begin
                tx_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else if (pend) begin
                pend     = 1'b0;
                tx_busy  = 1'b1;
                busy_cnt = $urandom_range(1, 5);
            end else begin
                tx_busy = 1'b0;
            end
            if (o_tx_start && !sender_dead) pend = 1'b1;
        end
    end

    // Monitor: checks every ACK and TX_START against the head of the expected queue.
    initial begin
        exp_t             e;
        logic [NREQ-1:0]  oh;
        forever begin
            @(negedge clk);
            if (o_idle && o_grant != '0) idle_grant_seen++;
            if (o_err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (o_ack != '0) begin
                ack_cnt++;
                last_ack_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack_unexpected: got ack %0h expected none", o_ack);
                end else begin
                    oh = '0;
                    oh[exp_q[0].id] = 1'b1;
                    chk("ack_id", 32'(o_ack), 32'(oh));
                    chk("ack_grant", 32'(o_grant), 32'(oh));
                end
            end
            if (o_tx_start) begin
                start_cnt++;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL start_unexpected: got data %02h expected none", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    $display("[%0d] tx byte req=%0d data=%02h", cyc, e.id, o_tx_data);
                    chk("tx_data", 32'(o_tx_data), 32'(e.data));
                    chk("tx_grant", 32'(o_grant), 32'(oh));
                end
            end
        end
    end

    task automatic batch_begin();
        for (int i = 0; i < NREQ; i++) begin
            rq_head[i] = 0;
            rq_cnt[i]  = 0;
        end
    endtask

    task automatic add_byte(input int id, input logic [7:0] d, input logic l);
        rq_d[id][rq_cnt[id]] = d;
        rq_l[id][rq_cnt[id]] = l;
        rq_cnt[id]++;
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NREQ; i++) begin
            if (rq_head[i] < rq_cnt[i]) begin
                tb_req[i]        = 1'b1;
                tb_data[8*i +: 8] = rq_d[i][rq_head[i]];
                tb_last[i]       = rq_l[i][rq_head[i]];
            end else begin
                tb_req[i]        = 1'b0;
                tb_data[8*i +: 8] = 8'h00;
                tb_last[i]       = 1'b0;
            end
        end
    endtask

    // Reference: each grant goes to the first pending requester after the previous winner,
    // except that an open packet (LAST=0) keeps the same owner while it still has bytes.
    task automatic model_expect();
        int   rem [NREQ];
        int   pos [NREQ];
        int   left, w, idx;
        exp_t e;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = rq_cnt[i] - rq_head[i];
            pos[i] = rq_head[i];
            left  += rem[i];
        end
        while (left > 0) begin
            w = -1;
            if (m_locked && rem[m_owner] > 0) begin
                w = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (w < 0 && rem[idx] > 0) w = idx;
                end
            end
            e.id   = w;
            e.data = rq_d[w][pos[w]];
            exp_q.push_back(e);
            m_locked = LOCK_EN && !rq_l[w][pos[w]];
            m_owner  = w;
            m_ptr    = w;
            pos[w]++;
            rem[w]--;
            left--;
        end
    endtask

    task automatic run(input int budget);
        int n;
        bit done;
        n = 0;
        drive_heads();
        forever begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NREQ; i++)
                if (o_ack[i] && rq_head[i] < rq_cnt[i]) rq_head[i]++;
            drive_heads();
            done = o_idle && (exp_q.size() == 0);
            for (int i = 0; i < NREQ; i++)
                if (rq_head[i] < rq_cnt[i]) done = 1'b0;
            if (done) break;
            if (n >= budget) begin
                total++; bad++;
                $display("FAIL run_timeout: got %0d cycles expected completion within %0d, %0d bytes pending",
                         n, budget, exp_q.size());
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        tb_req   = '0;
        tb_data  = '0;
        tb_last  = '0;
        pend     = 1'b0;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_ptr    = NREQ - 1;
        m_locked = 1'b0;
        m_owner  = 0;
        exp_q.delete();
        batch_begin();
    endtask

    initial begin
        int t0, a0, s0, e0, sv_ptr, rel, nb, ig0, c0;
        total = 0; bad = 0;
        ack_cnt = 0; start_cnt = 0; err_cnt = 0; idle_grant_seen = 0;
        last_ack_cyc = 0; last_start_cyc = 0; last_err_cyc = 0;
        force_busy = 1'b0; sender_dead = 1'b0;
        rst_n = 1'b0; tb_req = '0; tb_data = '0; tb_last = '0;

        do_reset();
        chk("rst_idle",     32'(o_idle),     32'd1);
        chk("rst_grant",    32'(o_grant),    32'd0);
        chk("rst_ack",      32'(o_ack),      32'd0);
        chk("rst_tx_start", 32'(o_tx_start), 32'd0);
        chk("rst_tx_data",  32'(o_tx_data),  32'd0);
        chk("rst_err",      32'(o_err),      32'd0);

        // Single byte: latency of ACK and TX_START.
        batch_begin();
        add_byte(0, 8'h41, 1'b1);
        model_expect();
        t0 = cyc; a0 = ack_cnt;
        run(500);
        chk("t1_ack_latency",   32'(last_ack_cyc - t0),   32'd1);
        chk("t1_start_latency", 32'(last_start_cyc - t0), 32'd2);
        chk("t1_idle",          32'(o_idle),  32'd1);
        chk("t1_grant_clear",   32'(o_grant), 32'd0);
        chk("t1_ack_count",     32'(ack_cnt - a0), 32'd1);

        // All requesters pending, two bytes each: strict rotation from requester 0.
        do_reset();
        batch_begin();
        for (int r = 0; r < NREQ; r++)
            for (int j = 0; j < 2; j++) add_byte(r, 8'($urandom), 1'b1);
        model_expect();
        a0 = ack_cnt; s0 = start_cnt;
        run(2000);
        chk("rot_ack_count",   32'(ack_cnt - a0),   32'(2 * NREQ));
        chk("rot_start_count", 32'(start_cnt - s0), 32'(2 * NREQ));

        // Sender never raises BUSY: ERR after BUSY_WAIT cycles, pointer unchanged.
        sender_dead = 1'b1;
        batch_begin();
        add_byte(2, 8'($urandom), 1'b1);
        sv_ptr = m_ptr;
        model_expect();
        m_ptr = sv_ptr; m_locked = 1'b0;
        e0 = err_cnt;
        run(500);
        @(negedge clk);
        chk("err_count",   32'(err_cnt - e0), 32'd1);
        chk("err_latency", 32'(last_err_cyc - last_start_cyc), 32'(BUSY_WAIT));
        chk("err_grant",   32'(o_grant), 32'd0);
        chk("err_idle",    32'(o_idle),  32'd1);
        sender_dead = 1'b0;

        // Recovery after ERR; order reveals whether the pointer moved.
        batch_begin();
        add_byte(1, 8'($urandom), 1'b1);
        add_byte(3, 8'($urandom), 1'b1);
        model_expect();
        run(1000);

        // Foreign BUSY holds off any grant.
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        batch_begin();
        add_byte(1, 8'($urandom), 1'b1);
        model_expect();
        drive_heads();
        a0 = ack_cnt; s0 = start_cnt;
        repeat (20) @(negedge clk);
        chk("busy_no_ack",   32'(ack_cnt - a0),   32'd0);
        chk("busy_no_start", 32'(start_cnt - s0), 32'd0);
        force_busy = 1'b0;
        rel = cyc;
        run(500);
        chk("busy_ack_after_release", 32'(last_ack_cyc > rel), 32'd1);

`ifdef UART_TX_ARB_LOCK_EN
        // Packet from requester 2 is not interleaved with requester 0.
        do_reset();
        batch_begin();
        add_byte(1, 8'($urandom), 1'b1);
        model_expect();
        run(500);
        batch_begin();
        add_byte(2, 8'($urandom), 1'b0);
        add_byte(2, 8'($urandom), 1'b0);
        add_byte(2, 8'($urandom), 1'b1);
        add_byte(0, 8'($urandom), 1'b1);
        model_expect();
        ig0 = idle_grant_seen;
        run(3000);
        chk("lock_grant_held", 32'(idle_grant_seen > ig0), 32'd1);

        // Abandoned packet: lock times out, then requester 3 is served.
        batch_begin();
        add_byte(1, 8'($urandom), 1'b0);
        model_expect();
        run(500);
        c0 = cyc;
        chk("lock_grant_idle", 32'(o_grant), 32'b0010);
        batch_begin();
        add_byte(3, 8'($urandom), 1'b1);
        model_expect();
        run(3000);
        chk("lock_timeout_latency", 32'(last_ack_cyc - c0), 32'(LOCK_TO + 1));
`endif

        // Random batches over random requester subsets.
        for (int b = 0; b < 6; b++) begin
            batch_begin();
            nb = 0;
            for (int r = 0; r < NREQ; r++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    logic l;
                    l = 1'($urandom_range(0, 1));
                    if (LOCK_EN && j == n - 1) l = 1'b1;
                    add_byte(r, 8'($urandom), l);
                    nb++;
                end
            end
            model_expect();
            a0 = ack_cnt;
            run(3000);
            chk("rand_ack_count", 32'(ack_cnt - a0), 32'(nb));
        end

`ifndef UART_TX_ARB_LOCK_EN
        chk("idle_grant_clear", 32'(idle_grant_seen), 32'd0);
`endif
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
